// File: rtl/zigzag_rle_pkg.sv
// Shared types and symbol constants for the zigzag run-length coder.
package rle_pkg;
  localparam int RUN_W  = 6;  // internal zero-run counter, covers up to 63 zeros
  localparam int SIZE_W = 4;

  typedef enum logic [1:0] {ST_LOAD, ST_SCAN, ST_ZRL} state_t;

  localparam logic [3:0] ZRL_RUN  = 4'd15;
  localparam logic [3:0] ZRL_SIZE = 4'd0;
  localparam logic [3:0] EOB_RUN  = 4'd0;
  localparam logic [3:0] EOB_SIZE = 4'd0;
endpackage

// File: rtl/zigzag_rle_size_cat.sv
// Coefficient value -> JPEG size category and right-aligned amplitude bits.
module rle_size_cat
  import rle_pkg::*;
#(
  parameter int BW = 8
) (
  input  logic signed [BW:0]       i_val,
  output logic        [SIZE_W-1:0] o_size,
  output logic        [BW:0]       o_amp
);
  logic [BW:0] w_abs, w_mask, w_m1;

  assign w_abs = i_val[BW] ? -i_val : i_val;

  always_comb begin
    o_size = '0;
    for (int i = 0; i <= BW; i++)
      if (w_abs[i]) o_size = SIZE_W'(i + 1);
  end

  // Negative values are coded as (v-1) truncated to 'size' bits.
  assign w_mask = ~({(BW+1){1'b1}} << o_size);
  assign w_m1   = i_val - {{BW{1'b0}}, 1'b1};
  assign o_amp  = i_val[BW] ? (w_m1 & w_mask) : i_val;
endmodule

// File: rtl/zigzag_rle.sv
// 8x8 zigzag block run-length coder emitting JPEG (run,size,amp) symbols.
// Define ZIGZAG_RLE_DC_DIFF_EN to code DC as a difference from the previous block.
module zigzag_rle
  import rle_pkg::*;
#(
  parameter int BW = 8
) (
  input  logic            i_clk,
  input  logic            i_Reset,
  input  logic [8*BW-1:0] i_data,
  input  logic            i_valid,
  output logic            o_in_ready,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [3:0]      o_run,
  output logic [3:0]      o_size,
  output logic [BW:0]     o_amp,
  output logic            o_last
);
  typedef struct packed {
    logic [3:0]  run;
    logic [3:0]  size;
    logic [BW:0] amp;
    logic        last;
  } sym_t;

  state_t                r_state, w_next;
  logic [2:0]            r_wcnt;
  logic signed [BW-1:0]  r_buf [64];
  logic [6:0]            r_idx;
  logic [RUN_W-1:0]      r_runc;
  logic                  r_valid;
  sym_t                  r_sym;

  logic                  w_xfer, w_adv, w_nz, w_ge16, w_at63, w_done;
  logic signed [BW-1:0]  w_coef;
  logic signed [BW:0]    w_dcval, w_cval;
  logic [SIZE_W-1:0]     w_size;
  logic [BW:0]           w_amp;
  sym_t                  w_csym, w_zrl, w_eob, w_dsym;

  assign w_xfer = i_valid && (r_state == ST_LOAD);
  assign w_adv  = !r_valid || i_ready;
  assign w_coef = r_buf[r_idx[5:0]];
  assign w_nz   = (w_coef != '0);
  assign w_ge16 = (r_runc[RUN_W-1:4] != '0);
  assign w_at63 = (r_idx == 7'd63);
  assign w_done = r_idx[6];

`ifdef ZIGZAG_RLE_DC_DIFF_EN
  logic signed [BW-1:0] r_pred;
  logic                 r_is_dc;

  assign w_dcval = {r_buf[0][BW-1], r_buf[0]} - {r_pred[BW-1], r_pred};

  // Predictor moves only once the DC symbol has actually left the block.
  always_ff @(posedge i_clk) begin
    if (!i_Reset) begin
      r_pred  <= '0;
      r_is_dc <= 1'b0;
    end else begin
      if (r_valid && i_ready && r_is_dc) r_pred <= r_buf[0];
      if (w_xfer && r_wcnt == 3'd7)      r_is_dc <= 1'b1;
      else if (r_valid && i_ready)       r_is_dc <= 1'b0;
    end
  end
`else
  assign w_dcval = {r_buf[0][BW-1], r_buf[0]};
`endif

  assign w_cval = (r_state == ST_LOAD) ? w_dcval : {w_coef[BW-1], w_coef};

  rle_size_cat #(.BW(BW)) u_cat (
    .i_val  (w_cval),
    .o_size (w_size),
    .o_amp  (w_amp)
  );

  assign w_csym = '{run: r_runc[3:0], size: w_size, amp: w_amp, last: w_at63};
  assign w_dsym = '{run: 4'd0, size: w_size, amp: w_amp, last: 1'b0};
  assign w_zrl  = '{run: ZRL_RUN, size: ZRL_SIZE, amp: '0, last: 1'b0};
  assign w_eob  = '{run: EOB_RUN, size: EOB_SIZE, amp: '0, last: 1'b1};

  always_ff @(posedge i_clk) begin
    if (!i_Reset) r_state <= ST_LOAD;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LOAD: if (w_xfer && r_wcnt == 3'd7) w_next = ST_SCAN;
      ST_SCAN: if (w_adv) begin
        if (r_valid && r_sym.last)        w_next = ST_LOAD;
        else if (!w_done && w_nz && w_ge16) w_next = ST_ZRL;
      end
      ST_ZRL:  if (w_adv && !w_ge16) w_next = ST_SCAN;
      default: w_next = ST_LOAD;
    endcase
  end

  always_comb begin
    o_in_ready = (r_state == ST_LOAD);
  end

  always_ff @(posedge i_clk) begin
    if (!i_Reset) begin
      for (int k = 0; k < 64; k++) r_buf[k] <= '0;
    end else if (w_xfer) begin
      for (int j = 0; j < 8; j++)
        r_buf[{r_wcnt, 3'(j)}] <= i_data[(7-j)*BW +: BW];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_Reset) begin
      r_wcnt  <= '0;
      r_idx   <= '0;
      r_runc  <= '0;
      r_valid <= 1'b0;
      r_sym   <= '0;
    end else begin
      case (r_state)
        ST_LOAD: if (w_xfer) begin
          r_wcnt <= r_wcnt + 3'd1;
          if (r_wcnt == 3'd7) begin
            r_valid <= 1'b1;
            r_sym   <= w_dsym;
            r_idx   <= 7'd1;
            r_runc  <= '0;
          end
        end
        ST_SCAN: if (w_adv) begin
          if (r_valid && r_sym.last) begin
            r_valid <= 1'b0;
            r_sym   <= '0;
          end else if (w_done) begin
            r_valid <= 1'b0;
          end else if (!w_nz) begin
            if (w_at63) begin
              r_valid <= 1'b1;
              r_sym   <= w_eob;
              r_idx   <= 7'd64;
              r_runc  <= '0;
            end else begin
              r_valid <= 1'b0;
              r_runc  <= r_runc + RUN_W'(1);
              r_idx   <= r_idx + 7'd1;
            end
          end else if (w_ge16) begin
            r_valid <= 1'b1;
            r_sym   <= w_zrl;
            r_runc  <= r_runc - RUN_W'(16);
          end else begin
            r_valid <= 1'b1;
            r_sym   <= w_csym;
            r_runc  <= '0;
            r_idx   <= r_idx + 7'd1;
          end
        end
        ST_ZRL: if (w_adv) begin
          r_valid <= 1'b1;
          if (w_ge16) begin
            r_sym  <= w_zrl;
            r_runc <= r_runc - RUN_W'(16);
          end else begin
            r_sym  <= w_csym;
            r_runc <= '0;
            r_idx  <= r_idx + 7'd1;
          end
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_run   = r_sym.run;
  assign o_size  = r_sym.size;
  assign o_amp   = r_sym.amp;
  assign o_last  = r_sym.last;
endmodule
